// File: rtl/dct_pkg.sv
// ==== dct_pkg : shared FSM state and pass encodings for the 2-D DCT scheduler ====
// ==== Rev 1.0                                                                  ====
`default_nettype none

package dct_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ROW      = 3'd1,
    ROW_WAIT = 3'd2,
    COL      = 3'd3,
    COL_WAIT = 3'd4,
    OUT      = 3'd5
  } state_t;

  localparam logic PASS_ROW = 1'b0;
  localparam logic PASS_COL = 1'b1;

endpackage

`default_nettype wire

// File: rtl/dct_fill_ctrl.sv
// ==== dct_fill_ctrl : ping-pong input-buffer fill counters, full flags, overflow ====
// ==== Rev 1.0                                                                    ====
`default_nettype none

module dct_fill_ctrl #(
  parameter int N  = 8,
  parameter int AW = $clog2(N*N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          rel_en,
  input  logic          rel_bank,
  output logic          wr_en,
  output logic          wr_bank,
  output logic [AW-1:0] wr_addr,
  output logic [1:0]    full,
  output logic          overflow
);
  import dct_pkg::*;

  localparam logic [AW-1:0] LAST_ADDR = AW'(N*N-1);

  logic          fill_bank;
  logic [AW-1:0] fill_addr;
  logic          accept;

  // The fill bank can only be full when the other one is too, so this is the drop condition.
  assign accept = valid && !full[fill_bank];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en     <= 1'b0;
      wr_bank   <= 1'b0;
      wr_addr   <= '0;
      full      <= 2'b00;
      fill_bank <= 1'b0;
      fill_addr <= '0;
      overflow  <= 1'b0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_bank <= fill_bank;
        wr_addr <= fill_addr;
      end
      if (rel_en)
        full[rel_bank] <= 1'b0;
      if (accept) begin
        if (fill_addr == LAST_ADDR) begin
          full[fill_bank] <= 1'b1;
          fill_bank       <= ~fill_bank;
          fill_addr       <= '0;
        end else begin
          fill_addr <= fill_addr + 1'b1;
        end
      end
      if (valid && !accept)
        overflow <= 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/dct_2d_sched.sv
// ==== dct_2d_sched : row/column pass scheduler and coefficient read sequencer ====
// ==== Rev 1.0                                                                 ====
`default_nettype none

module dct_2d_sched
  import dct_pkg::*;
#(
  parameter int N          = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_wr_en,
  output logic                     o_wr_bank,
  output logic [$clog2(N*N)-1:0]   o_wr_addr,
  output logic                     o_eng_start,
  output logic                     o_eng_pass,
  output logic [$clog2(N)-1:0]     o_eng_line,
  output logic                     o_eng_bank,
  input  logic                     i_eng_done,
  output logic                     o_rd_en,
  output logic [$clog2(N*N)-1:0]   o_rd_addr,
  output logic                     o_out_valid,
  output logic                     o_busy,
  output logic                     o_overflow
);

  localparam int AW = $clog2(N*N);
  localparam int LW = $clog2(N);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N*N-1);
  localparam logic [LW-1:0] LAST_LINE = LW'(N-1);

  state_t        state, state_nx;
  logic [LW-1:0] line, line_nx;
  logic          bank, bank_nx;
  logic          next_bank, next_bank_nx;
  logic [AW-1:0] rd_cnt, rd_cnt_nx;
  logic          rel_en;
  logic [1:0]    full;

  dct_fill_ctrl #(.N(N), .AW(AW)) u_fill (
    .clk      (i_clk),
    .rst      (i_rst),
    .valid    (i_valid),
    .rel_en   (rel_en),
    .rel_bank (bank),
    .wr_en    (o_wr_en),
    .wr_bank  (o_wr_bank),
    .wr_addr  (o_wr_addr),
    .full     (full),
    .overflow (o_overflow)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      line      <= '0;
      bank      <= 1'b0;
      next_bank <= 1'b0;
      rd_cnt    <= '0;
    end else begin
      state     <= state_nx;
      line      <= line_nx;
      bank      <= bank_nx;
      next_bank <= next_bank_nx;
      rd_cnt    <= rd_cnt_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    line_nx      = line;
    bank_nx      = bank;
    next_bank_nx = next_bank;
    rd_cnt_nx    = rd_cnt;
    rel_en       = 1'b0;
    case (state)
      // Banks fill in strict alternation, so the oldest full bank is always next_bank.
      IDLE: begin
        if (full[next_bank]) begin
          state_nx = ROW;
          bank_nx  = next_bank;
          line_nx  = '0;
        end
      end
      ROW: state_nx = ROW_WAIT;
      ROW_WAIT: begin
        if (i_eng_done) begin
          if (line == LAST_LINE) begin
            line_nx  = '0;
            state_nx = COL;
          end else begin
            line_nx  = line + 1'b1;
            state_nx = ROW;
          end
        end
      end
      COL: state_nx = COL_WAIT;
      COL_WAIT: begin
        if (i_eng_done) begin
          if (line == LAST_LINE) begin
            line_nx   = '0;
            rd_cnt_nx = '0;
            state_nx  = OUT;
          end else begin
            line_nx  = line + 1'b1;
            state_nx = COL;
          end
        end
      end
      OUT: begin
        // Release on the last read so the bank shows empty (and fillable) next cycle.
        if (rd_cnt == LAST_ADDR) begin
          rel_en       = 1'b1;
          next_bank_nx = ~next_bank;
          rd_cnt_nx    = '0;
          state_nx     = IDLE;
        end else begin
          rd_cnt_nx = rd_cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign o_eng_start = (state == ROW) || (state == COL);
  assign o_eng_pass  = ((state == COL) || (state == COL_WAIT)) ? PASS_COL : PASS_ROW;
  assign o_eng_line  = line;
  assign o_eng_bank  = bank;
  assign o_rd_en     = (state == OUT);
  assign o_rd_addr   = rd_cnt;
  assign o_busy      = (state != IDLE);

  logic [RD_LATENCY-1:0] vpipe;

  generate
    if (RD_LATENCY == 1) begin : g_lat1
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) vpipe <= '0;
        else       vpipe <= o_rd_en;
      end
    end else begin : g_latn
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) vpipe <= '0;
        else       vpipe <= {vpipe[RD_LATENCY-2:0], o_rd_en};
      end
    end
  endgenerate

  assign o_out_valid = vpipe[RD_LATENCY-1];

endmodule

`default_nettype wire

// File: tb/tb_dct_2d_sched.sv
// ==== tb_dct_2d_sched : directed self-checking bench for dct_2d_sched (N=8, latency 1 and 3) ====
// ==== Rev 1.0                                                                                ====
`default_nettype none

module tb_dct_2d_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic       inj_done = 1'b0;
  logic       m_done = 1'b0;
  logic       stall = 1'b0;
  logic       eng_done;

  logic       o_wr_en, o_wr_bank, o_eng_start, o_eng_pass, o_eng_bank;
  logic [5:0] o_wr_addr, o_rd_addr;
  logic [2:0] o_eng_line;
  logic       o_rd_en, o_out_valid, o_busy, o_overflow;

  logic       wr_en3, wr_bank3, eng_start3, eng_pass3, eng_bank3;
  logic [5:0] wr_addr3, rd_addr3;
  logic [2:0] eng_line3;
  logic       rd_en3, out_valid3, busy3, overflow3;

  int tests = 0;
  int fails = 0;
  int row_cnt[2];
  int col_cnt[2];
  int wr_cnt, rd_cnt, ov_cnt, ov3_cnt, cyc, last_rd, gap;
  int exp_wa, exp_wb, exp_ra, eng_cnt;
  logic [2:0] hist, hist3;

  assign eng_done = m_done | inj_done;

  always #5 clk = ~clk;

  dct_2d_sched #(.N(8), .RD_LATENCY(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid),
    .o_wr_en(o_wr_en), .o_wr_bank(o_wr_bank), .o_wr_addr(o_wr_addr),
    .o_eng_start(o_eng_start), .o_eng_pass(o_eng_pass), .o_eng_line(o_eng_line),
    .o_eng_bank(o_eng_bank), .i_eng_done(eng_done),
    .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_out_valid(o_out_valid),
    .o_busy(o_busy), .o_overflow(o_overflow)
  );

  dct_2d_sched #(.N(8), .RD_LATENCY(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_valid(valid),
    .o_wr_en(wr_en3), .o_wr_bank(wr_bank3), .o_wr_addr(wr_addr3),
    .o_eng_start(eng_start3), .o_eng_pass(eng_pass3), .o_eng_line(eng_line3),
    .o_eng_bank(eng_bank3), .i_eng_done(eng_done),
    .o_rd_en(rd_en3), .o_rd_addr(rd_addr3), .o_out_valid(out_valid3),
    .o_busy(busy3), .o_overflow(overflow3)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Engine model: done pulse 10 cycles after each start, unless stalled.
  always @(posedge clk) begin
    #1;
    m_done = 1'b0;
    if (rst) eng_cnt = 0;
    else begin
      if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) m_done = 1'b1;
      end
      if (o_eng_start && !stall) eng_cnt = 10;
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_wa = 0; exp_wb = 0; exp_ra = 0;
      hist = '0; hist3 = '0;
    end else begin
      if (o_eng_start) begin
        if (o_eng_pass) col_cnt[o_eng_bank]++;
        else            row_cnt[o_eng_bank]++;
        if (!o_eng_pass && o_eng_line == 0 && last_rd >= 0) gap = cyc - last_rd;
      end
      if (o_wr_en) begin
        chk("wr_addr_seq", o_wr_addr, exp_wa);
        chk("wr_bank_seq", o_wr_bank, exp_wb);
        wr_cnt++;
        if (exp_wa == 63) begin exp_wa = 0; exp_wb = 1 - exp_wb; end
        else exp_wa++;
      end
      if (o_rd_en) begin
        chk("rd_addr_seq", o_rd_addr, exp_ra);
        rd_cnt++;
        if (exp_ra == 63) begin exp_ra = 0; last_rd = cyc; end
        else exp_ra++;
      end
      if (hist[0] || o_out_valid) chk("out_valid_lat1", o_out_valid, hist[0]);
      if (hist3[2] || out_valid3) chk("out_valid_lat3", out_valid3, hist3[2]);
      if (o_out_valid) ov_cnt++;
      if (out_valid3)  ov3_cnt++;
      hist  = {hist[1:0], o_rd_en};
      hist3 = {hist3[1:0], rd_en3};
    end
  end

  task automatic clear_counts();
    row_cnt[0] = 0; row_cnt[1] = 0; col_cnt[0] = 0; col_cnt[1] = 0;
    wr_cnt = 0; rd_cnt = 0; ov_cnt = 0; ov3_cnt = 0; last_rd = -1; gap = -1;
  endtask

  task automatic send(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1; valid = 1'b1;
    end
    @(posedge clk); #1; valid = 1'b0;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input int target, input int bound, input string tag);
    int n = 0;
    while (!(rd_cnt >= target && !o_busy) && n < bound) begin
      @(negedge clk); n++;
    end
    chk(tag, n < bound, 1'b1);
    repeat (5) @(negedge clk);
    #1;
  endtask

  task automatic chk_counts(input string tag, input int r0, input int r1, input int nrd);
    chk({tag, "_row_b0"}, row_cnt[0], r0);
    chk({tag, "_col_b0"}, col_cnt[0], r0);
    chk({tag, "_row_b1"}, row_cnt[1], r1);
    chk({tag, "_col_b1"}, col_cnt[1], r1);
    chk({tag, "_rd_cnt"}, rd_cnt, nrd);
    chk({tag, "_ov_cnt"}, ov_cnt, nrd);
    chk({tag, "_ov3_cnt"}, ov3_cnt, nrd);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    eng_cnt = 0; cyc = 0;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_en", o_wr_en, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_eng_start", o_eng_start, 0);
    chk("rst_rd_en", o_rd_en, 0);
    chk("rst_out_valid", o_out_valid, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_eng_fields", {o_eng_pass, o_eng_line, o_eng_bank}, 0);
    rst = 1'b0;

    // Stray done while idle
    @(posedge clk); #1; inj_done = 1'b1;
    @(posedge clk); #1; inj_done = 1'b0;
    sample();
    chk("idle_done_busy", o_busy, 0);
    chk("idle_done_line", o_eng_line, 0);

    // Single block of 64 with first-write latency check
    @(posedge clk); #1; valid = 1'b1;
    @(negedge clk); #1;
    chk("wr_lat_k", o_wr_en, 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("wr_lat_k1_en", o_wr_en, 1);
    chk("wr_lat_k1_addr", o_wr_addr, 0);
    chk("wr_lat_k1_bank", o_wr_bank, 0);
    repeat (62) begin @(posedge clk); #1; end
    @(posedge clk); #1; valid = 1'b0;
    wait_done(64, 1500, "blk1_done");
    chk_counts("blk1", 8, 0, 64);
    chk("blk1_wr_cnt", wr_cnt, 64);
    chk("blk1_overflow", o_overflow, 0);

    // 128 back-to-back; done injected during ROW must be ignored
    clear_counts();
    fork
      send(128);
      begin
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!o_eng_start && n < 300);
        chk("row_start_seen", o_eng_start, 1);
        inj_done = 1'b1;
        @(posedge clk); #1; inj_done = 1'b0;
        sample();
        chk("row_done_ign_start", o_eng_start, 0);
        chk("row_done_ign_line", o_eng_line, 0);
        chk("row_done_ign_busy", o_busy, 1);
      end
    join
    wait_done(128, 3000, "blk2_done");
    chk_counts("blk2", 8, 8, 128);
    chk("blk2_wr_cnt", wr_cnt, 128);
    chk("blk2_overflow", o_overflow, 0);
    chk("blk2_idle_gap", gap, 2);

    // Stalled engine, 192 samples: last 64 dropped
    clear_counts();
    stall = 1'b1;
    send(128);
    sample();
    chk("stall_ovf_before", o_overflow, 0);
    chk("stall_wr_128", wr_cnt, 128);
    send(64);
    sample();
    chk("stall_ovf_after", o_overflow, 1);
    chk("stall_wr_dropped", wr_cnt, 128);
    chk("stall_line_held", o_eng_line, 0);
    stall = 1'b0;
    @(posedge clk); #1; inj_done = 1'b1;
    @(posedge clk); #1; inj_done = 1'b0;
    wait_done(128, 3000, "stall_done");
    chk_counts("stall", 8, 8, 128);
    chk("stall_ovf_sticky", o_overflow, 1);
    @(posedge clk); #1; rst = 1'b1;
    sample();
    chk("stall_rst_ovf", o_overflow, 0);
    chk("stall_rst_busy", o_busy, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Asynchronous reset during COL_WAIT line 3
    clear_counts();
    send(64);
    n = 0;
    do begin @(posedge clk); #1; n++; end
    while (!(o_busy && o_eng_pass && o_eng_line == 3 && !o_eng_start) && n < 1000);
    chk("colwait3_seen", n < 1000, 1);
    #2; rst = 1'b1;
    #1;
    chk("arst_busy", o_busy, 0);
    chk("arst_eng_start", o_eng_start, 0);
    chk("arst_eng_fields", {o_eng_pass, o_eng_line, o_eng_bank}, 0);
    chk("arst_rd", {o_rd_en, o_rd_addr}, 0);
    chk("arst_wr", {o_wr_en, o_wr_bank, o_wr_addr}, 0);
    chk("arst_valid", {o_out_valid, out_valid3}, 0);
    chk("arst_overflow", o_overflow, 0);
    @(posedge clk); @(posedge clk); #1; rst = 1'b0;
    clear_counts();
    send(64);
    wait_done(64, 1500, "post_rst_done");
    chk_counts("post_rst", 8, 0, 64);
    chk("post_rst_wr_cnt", wr_cnt, 64);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
